// File: rtl/crc12_framer_pkg.sv
// Shared definitions for the CRC-12 frame sequencer: generator polynomial,
// initial value and the frame FSM state encoding.
package crc12_framer_pkg;

  localparam logic [11:0] CRC12_POLY = 12'h80F;
  localparam logic [11:0] CRC12_INIT = 12'h000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    CRC_HI = 2'd2,
    CRC_LO = 2'd3
  } state_e;

endpackage

// File: rtl/crc12_framer_step.sv
// One-byte CRC-12 update, MSB first, no reflection. Purely combinational so
// the same block can serve both the framer and the standalone crc12 engine.
module crc12_step
  import crc12_framer_pkg::*;
(
  input  logic [11:0] crc_in,
  input  logic [7:0]  data,
  output logic [11:0] crc_out
);

  logic [11:0] c;

  // Fold the byte into the top of the register, then run eight divide steps.
  always_comb begin
    c = crc_in ^ {data, 4'b0000};
    for (int i = 0; i < 8; i++) begin
      if (c[11]) c = {c[10:0], 1'b0} ^ CRC12_POLY;
      else       c = {c[10:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/crc12_framer.sv
// TX frame sequencer: forwards payload bytes through a single output slot,
// runs CRC-12 over each frame, appends a two-byte trailer and force-closes
// frames that reach MAX_LEN payload bytes.
module crc12_framer
  import crc12_framer_pkg::*;
#(
  parameter int MAX_LEN = 256
) (
  input  logic        clk,
  input  logic        arst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic [11:0] crc,
  output logic        crc_done,
  output logic        len_err,
  output logic        busy
);

  localparam int LW = $clog2(MAX_LEN + 1);

  state_e          state_q, state_d;
  logic [LW-1:0]   len_q, len_d, len_inc;
  logic [11:0]     crc_r_q, crc_r_d;
  logic [11:0]     crc_q, crc_d;
  logic [11:0]     step_in, step_out;
  logic [7:0]      m_data_q, m_data_d;
  logic            m_valid_q, m_valid_d;
  logic            m_last_q, m_last_d;
  logic            crc_done_q, crc_done_d;
  logic            len_err_q, len_err_d;
  logic            slot_free, accept, at_max, in_payload;

  assign slot_free  = !m_valid_q || m_ready;
  assign in_payload = (state_q == IDLE) || (state_q == DATA);
  // Gate with arst so nothing looks acceptable while the block is held in reset.
  assign s_ready    = !arst && in_payload && slot_free;
  assign accept     = s_valid && s_ready;
  assign len_inc    = len_q + LW'(1);
  assign at_max     = (len_inc == LW'(MAX_LEN));

  // A new frame always starts from the init value, regardless of crc_r_q.
  assign step_in = (state_q == IDLE) ? CRC12_INIT : crc_r_q;

  crc12_step u_step (
    .crc_in  (step_in),
    .data    (s_data),
    .crc_out (step_out)
  );

  // Next-state and output-slot logic for the frame FSM.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    crc_r_d    = crc_r_q;
    crc_d      = crc_q;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;
    m_valid_d  = m_valid_q && !m_ready;
    crc_done_d = 1'b0;
    len_err_d  = 1'b0;
    case (state_q)
      IDLE, DATA: begin
        if (accept) begin
          m_data_d  = s_data;
          m_valid_d = 1'b1;
          m_last_d  = 1'b0;
          crc_r_d   = step_out;
          len_d     = len_inc;
          len_err_d = at_max && !s_last;
          state_d   = (s_last || at_max) ? CRC_HI : DATA;
        end
      end
      CRC_HI: begin
        if (slot_free) begin
          m_data_d  = {4'h0, crc_r_q[11:8]};
          m_valid_d = 1'b1;
          m_last_d  = 1'b0;
          state_d   = CRC_LO;
        end
      end
      CRC_LO: begin
        if (slot_free) begin
          m_data_d   = crc_r_q[7:0];
          m_valid_d  = 1'b1;
          m_last_d   = 1'b1;
          crc_d      = crc_r_q;
          crc_done_d = 1'b1;
          crc_r_d    = CRC12_INIT;
          len_d      = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Datapath, output slot and status registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      len_q      <= '0;
      crc_r_q    <= CRC12_INIT;
      crc_q      <= CRC12_INIT;
      m_data_q   <= 8'h00;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      crc_done_q <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      len_q      <= len_d;
      crc_r_q    <= crc_r_d;
      crc_q      <= crc_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      crc_done_q <= crc_done_d;
      len_err_q  <= len_err_d;
    end
  end

  assign m_data   = m_data_q;
  assign m_valid  = m_valid_q;
  assign m_last   = m_last_q;
  assign crc      = crc_q;
  assign crc_done = crc_done_q;
  assign len_err  = len_err_q;
  assign busy     = (state_q != IDLE) || m_valid_q;

endmodule

// File: tb/tb_crc12_framer.sv
// Bench for crc12_framer: directed frames plus randomized traffic, checked
// each cycle against a queue of expected output beats built from a
// polynomial-division CRC model.
module tb_crc12_framer;

  localparam int MAXL = 4;

  logic        clk;
  logic        arst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  logic [11:0] crc;
  logic        crc_done;
  logic        len_err;
  logic        busy;

  crc12_framer #(.MAX_LEN(MAXL)) dut (
    .clk      (clk),
    .arst     (arst),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_last   (m_last),
    .m_ready  (m_ready),
    .crc      (crc),
    .crc_done (crc_done),
    .len_err  (len_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  d;
    bit          last;
    bit          lerr;
    logic [11:0] crc;
  } beat_t;

  beat_t      expq[$];
  logic [7:0] cur[$];
  int         mlen;
  int         checks;
  int         errors;
  int         cyc;
  int         xfer_cyc[$];
  int         done_cnt;
  int         lerr_cnt;
  bit         rnd_ready;
  bit         run;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // CRC as the remainder of (message * x^12) divided by x^12+x^11+x^3+x^2+x+1.
  function automatic logic [11:0] crc_model(input logic [7:0] msg[$]);
    logic [12:0] r;
    r = '0;
    foreach (msg[i]) begin
      for (int b = 7; b >= 0; b--) begin
        r = {r[11:0], msg[i][b]};
        if (r[12]) r = r ^ 13'h180F;
      end
    end
    for (int b = 0; b < 12; b++) begin
      r = {r[11:0], 1'b0};
      if (r[12]) r = r ^ 13'h180F;
    end
    return r[11:0];
  endfunction

  // Record one accepted payload byte; close the frame on s_last or MAX_LEN.
  function automatic void model_accept(input logic [7:0] d, input logic l);
    beat_t       b;
    bit          term;
    logic [11:0] c;
    cur.push_back(d);
    mlen++;
    term   = l || (mlen == MAXL);
    b.d    = d;
    b.last = 1'b0;
    b.lerr = (mlen == MAXL) && !l;
    b.crc  = 12'h000;
    expq.push_back(b);
    if (term) begin
      c      = crc_model(cur);
      b.d    = {4'h0, c[11:8]};
      b.lerr = 1'b0;
      expq.push_back(b);
      b.d    = c[7:0];
      b.last = 1'b1;
      b.crc  = c;
      expq.push_back(b);
      cur.delete();
      mlen = 0;
    end
  endfunction

  task automatic send(input logic [7:0] d, input logic l);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    s_data = d;
    s_last = l;
    s_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: byte %0h never accepted", d);
        break;
      end
    end
    if (acc) model_accept(d, l);
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d beats still expected, busy=%0b", expq.size(), busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_m_data"}, 32'(m_data), 32'd0);
    chk({tag, "_m_last"}, 32'(m_last), 32'd0);
    chk({tag, "_crc"}, 32'(crc), 32'd0);
    chk({tag, "_crc_done"}, 32'(crc_done), 32'd0);
    chk({tag, "_len_err"}, 32'(len_err), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
  endtask

  // Random downstream back-pressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Per-cycle compare of the output slot against the expected beat queue.
  initial begin
    bit         stalled_prev;
    logic [7:0] prev_d;
    logic       prev_l;
    stalled_prev = 1'b0;
    prev_d = 8'h00;
    prev_l = 1'b0;
    forever begin
      @(negedge clk);
      if (arst || !run) begin
        stalled_prev = 1'b0;
      end else begin
        cyc++;
        if (stalled_prev) begin
          chk("hold_valid", 32'(m_valid), 32'd1);
          chk("hold_data", 32'(m_data), 32'(prev_d));
          chk("hold_last", 32'(m_last), 32'(prev_l));
        end
        if (m_valid && !stalled_prev) begin
          if (expq.size() == 0) begin
            chk("extra_beat", 32'(expq.size()), 32'd1);
          end else begin
            chk("beat_data", 32'(m_data), 32'(expq[0].d));
            chk("beat_last", 32'(m_last), 32'(expq[0].last));
            chk("crc_done", 32'(crc_done), 32'(expq[0].last));
            chk("len_err", 32'(len_err), 32'(expq[0].lerr));
            if (expq[0].last) chk("crc_value", 32'(crc), 32'(expq[0].crc));
          end
        end else begin
          chk("done_quiet", 32'(crc_done), 32'd0);
          chk("lerr_quiet", 32'(len_err), 32'd0);
        end
        chk("busy", 32'(busy), 32'(expq.size() > 0 || mlen > 0));
        if (m_valid && !m_ready) chk("sready_full", 32'(s_ready), 32'd0);
        if (crc_done) done_cnt++;
        if (len_err) lerr_cnt++;
        if (m_valid && m_ready) begin
          if (expq.size() > 0) void'(expq.pop_front());
          xfer_cyc.push_back(cyc);
        end
        stalled_prev = m_valid && !m_ready;
        prev_d = m_data;
        prev_l = m_last;
      end
    end
  end

  initial begin
    logic [7:0] tq[$];
    int d0, l0, x0, flen;
    arst = 1'b1;
    s_valid = 1'b0;
    s_data = 8'h00;
    s_last = 1'b0;
    m_ready = 1'b0;
    rnd_ready = 1'b0;
    run = 1'b0;
    checks = 0;
    errors = 0;
    mlen = 0;
    cyc = 0;
    done_cnt = 0;
    lerr_cnt = 0;

    // Pin the reference model with hand-computed remainders.
    tq.delete(); tq.push_back(8'h01);
    chk("model_01", 32'(crc_model(tq)), 32'h80F);
    tq.delete(); tq.push_back(8'h00);
    chk("model_00", 32'(crc_model(tq)), 32'h000);
    tq.delete(); tq.push_back(8'h01); tq.push_back(8'h00); tq.push_back(8'h00);
    chk("model_010000", 32'(crc_model(tq)), 32'hC45);

    repeat (3) @(negedge clk);
    reset_checks("rst0");
    @(posedge clk);
    #1;
    arst = 1'b0;
    run = 1'b1;
    m_ready = 1'b1;

    // Single frame {0x01}.
    d0 = done_cnt;
    send(8'h01, 1'b1);
    wait_drain();
    chk("f01_crc", 32'(crc), 32'h80F);
    chk("f01_done_count", 32'(done_cnt - d0), 32'd1);

    // Single frame {0x00}.
    send(8'h00, 1'b1);
    wait_drain();
    chk("f00_crc", 32'(crc), 32'h000);

    // Two back-to-back frames {0x01},{0x01} without bubbles.
    x0 = xfer_cyc.size();
    d0 = done_cnt;
    send(8'h01, 1'b1);
    send(8'h01, 1'b1);
    wait_drain();
    chk("b2b_beats", 32'(xfer_cyc.size() - x0), 32'd6);
    if (xfer_cyc.size() >= x0 + 6)
      chk("b2b_span", 32'(xfer_cyc[x0 + 5] - xfer_cyc[x0]), 32'd5);
    chk("b2b_done_count", 32'(done_cnt - d0), 32'd2);
    chk("b2b_crc", 32'(crc), 32'h80F);

    // Frame {0x01,0x00,0x00} with a three-cycle downstream stall.
    fork
      begin
        send(8'h01, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b1);
      end
      begin
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        m_ready = 1'b1;
      end
    join
    wait_drain();
    chk("stall_crc", 32'(crc), 32'hC45);

    // Five bytes of 0x01, s_last only on the fifth: forced split at MAX_LEN.
    d0 = done_cnt;
    l0 = lerr_cnt;
    for (int i = 0; i < 5; i++) send(8'h01, (i == 4));
    wait_drain();
    chk("maxlen_lerr_count", 32'(lerr_cnt - l0), 32'd1);
    chk("maxlen_done_count", 32'(done_cnt - d0), 32'd2);
    chk("maxlen_crc", 32'(crc), 32'h80F);

    // Reset in the middle of a 4-byte frame, then a fresh frame.
    d0 = done_cnt;
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    arst = 1'b1;
    @(negedge clk);
    reset_checks("rst_mid");
    expq.delete();
    cur.delete();
    mlen = 0;
    @(posedge clk);
    #1;
    arst = 1'b0;
    send(8'h01, 1'b1);
    wait_drain();
    chk("post_rst_crc", 32'(crc), 32'h80F);
    chk("post_rst_done_count", 32'(done_cnt - d0), 32'd1);

    // Randomized frames, gaps and back-pressure.
    rnd_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      flen = $urandom_range(1, 6);
      for (int i = 0; i < flen; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) begin
            @(posedge clk);
            #1;
          end
        end
        send(8'($urandom_range(0, 255)), (i == flen - 1));
      end
    end
    rnd_ready = 1'b0;
    m_ready = 1'b1;
    wait_drain();
    chk("final_queue_empty", 32'(expq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
